// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, control encodings, FSM state enum and control-word type for the multicycle main controller.
package mc_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_RTYPE = 3'b100;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_J};
    endfunction
endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational state/opcode to control-word decoder.
//   state     - current controller state
//   op        - instruction opcode (IR[31:26])
//   mem_ready - memory completion, gates ir_write/pc_write in FETCH only
//   ctrl      - decoded control word
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_BRANCH;
                ctrl.illegal_op = !op_legal(op);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl.mem_req = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = op == OP_ANDI ? ALU_AND : ALU_ADD;
            end
            // alu_op is held from I_EXEC so the ALU result stays valid during write-back
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = op == OP_ANDI ? ALU_AND : ALU_ADD;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PC_ALUOUT;
                ctrl.branch_eq = op == OP_BEQ;
                ctrl.branch_ne = op == OP_BNE;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_main_control.sv
// mc_main_control: multicycle main controller (state register, next-state logic, retired-instruction counter).
//   clk, rst_n       - clock, async active-low reset
//   op, mem_ready    - opcode from IR, memory completion
//   mem_req..illegal_op - datapath/memory control outputs (Moore, FETCH write enables gated by mem_ready)
//   instr_count      - retired instructions, wraps modulo 2^CNT_W
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch_eq,
    output logic             branch_ne,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);
    state_t state, state_nx;
    ctrl_t  ctrl;
    logic   retire;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = S_FETCH;
        case (state)
            S_FETCH:     state_nx = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (op)
                    OP_LW, OP_SW:     state_nx = S_MEM_ADDR;
                    OP_RTYPE:         state_nx = S_R_EXEC;
                    OP_ADDI, OP_ANDI: state_nx = S_I_EXEC;
                    OP_BEQ, OP_BNE:   state_nx = S_BRANCH;
                    OP_J:             state_nx = S_JUMP;
                    default:          state_nx = S_FETCH;
                endcase
            S_MEM_ADDR:  state_nx = op == OP_SW ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_nx = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_nx = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_nx = S_R_WB;
            S_I_EXEC:    state_nx = S_I_WB;
            default:     state_nx = S_FETCH;
        endcase
    end

    assign retire = state inside {S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP}
                    || (state == S_MEM_WRITE && mem_ready);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) instr_count <= '0;
        else if (retire) instr_count <= instr_count + CNT_W'(1);

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .op        (op),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign i_or_d     = ctrl.i_or_d;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign branch_eq  = ctrl.branch_eq;
    assign branch_ne  = ctrl.branch_ne;
    assign pc_source  = ctrl.pc_source;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign illegal_op = ctrl.illegal_op;
endmodule
